// File: rtl/axi_resize_timestamp.sv
// Re-frames a CVITA sample stream into fixed-length output packets with regenerated headers and timestamps.
// Defining AXI_RESIZE_TIMESTAMP_PKTCNT_EN adds the rb_pkt_cnt output packet counter.
module axi_resize_timestamp #(
    parameter int          WIDTH        = 32,
    parameter logic [7:0]  SR_BASE      = 8'd128,
    parameter logic [15:0] DEF_PKT_LEN  = 16'd256,
    parameter logic [31:0] DEF_TIME_INC = 32'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [15:0]      next_dst,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic [127:0]     s_axis_tuser,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic [127:0]     m_axis_tuser,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
`ifdef AXI_RESIZE_TIMESTAMP_PKTCNT_EN
    ,
    output logic [31:0]      rb_pkt_cnt
`endif
);

    localparam logic [7:0] ADDR_PKT_LEN  = SR_BASE;
    localparam logic [7:0] ADDR_TIME_INC = SR_BASE + 8'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_len_cfg;
    logic [31:0] r_inc_cfg;
    logic [15:0] r_pkt_len;
    logic [31:0] r_time_inc;
    logic [15:0] r_cnt;
    logic [11:0] r_seq;
    logic [63:0] r_time_accum;
    logic [63:0] r_pkt_ts;
    logic [1:0]  r_type;
    logic        r_has_time;
    logic [15:0] r_src;

    logic        w_acc;
    logic        w_flush;
    logic        w_eob;
    logic        w_tlast;
    logic [15:0] w_len;
    logic [31:0] w_inc;
    logic [63:0] w_base;
    logic [63:0] w_ts;
    logic [1:0]  w_type;
    logic        w_has_time;
    logic [15:0] w_src;
    logic        w_unused_bits;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = s_axis_tvalid;
    assign s_axis_tready = m_axis_tready;

    assign w_acc   = s_axis_tvalid & m_axis_tready;
    assign w_flush = (~reset) | clear;
    // Header length field and upper settings bits are not consumed here.
    assign w_unused_bits = ^{set_data[31:16], s_axis_tuser[123:80]};

    // Next-state logic plus header/tlast generation; the first beat of a burst reads its fields straight from tuser.
    always_comb begin
        w_state_nxt = r_state;
        w_type      = r_type;
        w_has_time  = r_has_time;
        w_src       = r_src;
        w_base      = r_time_accum;
        w_len       = r_pkt_len;
        w_inc       = r_time_inc;
        w_ts        = r_pkt_ts;
        m_axis_tlast = 1'b0;
        m_axis_tuser = 128'd0;

        case (r_state)
            ST_IDLE: begin
                w_type     = s_axis_tuser[127:126];
                w_has_time = s_axis_tuser[125];
                w_src      = s_axis_tuser[79:64];
                w_base     = s_axis_tuser[63:0];
            end
            ST_RUN: begin
                w_type     = r_type;
                w_has_time = r_has_time;
                w_src      = r_src;
                w_base     = r_time_accum;
            end
            default: begin
                w_type     = r_type;
                w_has_time = r_has_time;
                w_src      = r_src;
                w_base     = r_time_accum;
            end
        endcase

        // Settings only apply from an output packet's first beat onward.
        if (r_cnt == 16'd0) begin
            w_len = (r_len_cfg == 16'd0) ? 16'd1 : r_len_cfg;
            w_inc = r_inc_cfg;
            w_ts  = w_base;
        end else begin
            w_len = r_pkt_len;
            w_inc = r_time_inc;
            w_ts  = r_pkt_ts;
        end

        w_eob   = s_axis_tvalid & s_axis_tlast & s_axis_tuser[124];
        w_tlast = w_eob | (r_cnt == (w_len - 16'd1));

        case (r_state)
            ST_IDLE: begin
                if (w_acc && !w_eob) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_acc && w_eob) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (reset) begin
            m_axis_tlast = w_tlast;
            m_axis_tuser = {w_type, w_has_time, w_eob, r_seq, 16'd0, w_src, next_dst, w_ts};
        end else begin
            m_axis_tlast = 1'b0;
            m_axis_tuser = 128'd0;
        end
    end

    // Settings registers survive clear; only reset restores defaults.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_len_cfg <= DEF_PKT_LEN;
            r_inc_cfg <= DEF_TIME_INC;
        end else if (set_stb) begin
            case (set_addr)
                ADDR_PKT_LEN:  r_len_cfg <= set_data[15:0];
                ADDR_TIME_INC: r_inc_cfg <= set_data;
                default: begin
                    r_len_cfg <= r_len_cfg;
                    r_inc_cfg <= r_inc_cfg;
                end
            endcase
        end
    end

    // Burst state, beat counter, sequence number and timestamp accumulator.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 16'd0;
            r_seq        <= 12'd0;
            r_time_accum <= 64'd0;
            r_pkt_ts     <= 64'd0;
            r_pkt_len    <= DEF_PKT_LEN;
            r_time_inc   <= DEF_TIME_INC;
            r_type       <= 2'd0;
            r_has_time   <= 1'b0;
            r_src        <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_time_accum <= w_base + {32'd0, w_inc};
                r_cnt        <= w_tlast ? 16'd0 : (r_cnt + 16'd1);
                if (w_tlast) begin
                    r_seq <= r_seq + 12'd1;
                end
                if (r_cnt == 16'd0) begin
                    r_pkt_len  <= w_len;
                    r_time_inc <= w_inc;
                    r_pkt_ts   <= w_base;
                end
                if (r_state == ST_IDLE) begin
                    r_type     <= w_type;
                    r_has_time <= w_has_time;
                    r_src      <= w_src;
                end
            end
        end
    end

`ifdef AXI_RESIZE_TIMESTAMP_PKTCNT_EN
    logic [31:0] r_pkt_cnt;

    // Counts output packets (tlast beats), wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_pkt_cnt <= 32'd0;
        end else if (w_acc && w_tlast) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
    end

    assign rb_pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_axi_resize_timestamp.sv
// Randomized self-checking bench for axi_resize_timestamp against a packet-level reference model.
module tb_axi_resize_timestamp;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clear = 1'b0;
    logic         set_stb = 1'b0;
    logic [7:0]   set_addr = 8'd0;
    logic [31:0]  set_data = 32'd0;
    logic [15:0]  next_dst = 16'h1234;
    logic [31:0]  s_tdata = 32'd0;
    logic [127:0] s_tuser = 128'd0;
    logic         s_tlast = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [31:0]  m_tdata;
    logic [127:0] m_tuser;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
`ifdef AXI_RESIZE_TIMESTAMP_PKTCNT_EN
    logic [31:0]  rb_pkt_cnt;
`endif

    always #5 clk = ~clk;

    axi_resize_timestamp dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data), .next_dst(next_dst),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
`ifdef AXI_RESIZE_TIMESTAMP_PKTCNT_EN
        , .rb_pkt_cnt(rb_pkt_cnt)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;
    bit stall_en = 1'b0;

    // Reference model: settings, current burst header, running time, packet position.
    logic [15:0]       cfg_len;
    logic [31:0]       cfg_inc;
    bit                mb_active;
    logic [1:0]        mb_type;
    logic              mb_ht;
    logic [15:0]       mb_src;
    logic [63:0]       mb_acc;
    logic [63:0]       mb_ts;
    logic [31:0]       mb_inc;
    int                mb_pos;
    int                mb_len;
    logic [11:0]       mb_seq;
    logic [31:0]       mb_pkts;

    // Observed output packets: first-beat timestamp, seqnum and length.
    logic [63:0] obs_ts[$];
    logic [11:0] obs_seq[$];
    int          obs_len[$];
    int          ob_beats;
    bit          ob_first;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input bit full);
        mb_active = 1'b0;
        mb_pos    = 0;
        mb_seq    = 12'd0;
        mb_acc    = 64'd0;
        mb_pkts   = 32'd0;
        if (full) begin
            cfg_len = 16'd256;
            cfg_inc = 32'd1;
        end
    endtask

    task automatic clear_obs();
        obs_ts.delete();
        obs_seq.delete();
        obs_len.delete();
        ob_beats = 0;
        ob_first = 1'b1;
    endtask

    task automatic check_pktcnt();
`ifdef AXI_RESIZE_TIMESTAMP_PKTCNT_EN
        check_val("pktcnt", 128'(rb_pkt_cnt), 128'(mb_pkts));
`endif
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [127:0] u, input logic l);
        logic [127:0] eu;
        logic         el;
        logic         eob;
        int           tries;
        bit           done;
        if (!mb_active) begin
            mb_type = u[127:126];
            mb_ht   = u[125];
            mb_src  = u[79:64];
            mb_acc  = u[63:0];
        end
        if (mb_pos == 0) begin
            mb_len = (cfg_len == 16'd0) ? 1 : int'(cfg_len);
            mb_inc = cfg_inc;
            mb_ts  = mb_acc;
        end
        eob = l & u[124];
        el  = eob | (mb_pos == mb_len - 1);
        eu  = {mb_type, mb_ht, eob, mb_seq, 16'h0000, mb_src, next_dst, mb_ts};
        tries = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = d;
            s_tuser  = u;
            s_tlast  = l;
            m_tready = (stall_en && tries < 40) ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            check_val("tdata", 128'(m_tdata), 128'(d));
            check_val("tvalid", 128'(m_tvalid), 128'd1);
            check_val("tready", 128'(s_tready), 128'(m_tready));
            check_val("tuser", m_tuser, eu);
            check_val("tlast", 128'(m_tlast), 128'(el));
            done = m_tready;
            tries++;
        end
        if (ob_first) begin
            obs_ts.push_back(m_tuser[63:0]);
            obs_seq.push_back(m_tuser[123:112]);
            ob_first = 1'b0;
        end
        ob_beats++;
        if (m_tlast) begin
            obs_len.push_back(ob_beats);
            ob_beats = 0;
            ob_first = 1'b1;
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        mb_acc = mb_acc + {32'd0, mb_inc};
        mb_pos = el ? 0 : mb_pos + 1;
        if (el) begin
            mb_seq  = mb_seq + 12'd1;
            mb_pkts = mb_pkts + 32'd1;
        end
        mb_active = !eob;
    endtask

    task automatic send_pkt(input int n, input logic [127:0] u);
        for (int i = 0; i < n; i++) begin
            send_beat($urandom, u, (i == n - 1));
        end
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] v);
        @(negedge clk);
        s_tvalid = 1'b0;
        set_stb  = 1'b1;
        set_addr = a;
        set_data = v;
        @(negedge clk);
        set_stb = 1'b0;
        if (a == 8'd128) cfg_len = v[15:0];
        else if (a == 8'd129) cfg_inc = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            m_tready = ($urandom_range(0, 1) != 0);
            #1;
            check_val("idle_tready", 128'(s_tready), 128'(m_tready));
        end
    endtask

    task automatic do_reset();
        logic [127:0] u;
        u = {$urandom, $urandom, $urandom, $urandom};
        u[124] = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
        s_tuser  = u;
        s_tlast  = 1'b1;
        m_tready = 1'b1;
        #1;
        check_val("rst_tuser", m_tuser, 128'd0);
        check_val("rst_tlast", 128'(m_tlast), 128'd0);
        check_val("rst_tdata", 128'(m_tdata), 128'(s_tdata));
        check_val("rst_tready", 128'(s_tready), 128'd1);
        @(negedge clk);
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        model_reset(1'b1);
        clear_obs();
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear    = 1'b1;
        s_tvalid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        model_reset(1'b0);
        clear_obs();
    endtask

    task automatic check_pkts(input string tag, input int n, input int el[8],
                              input logic [63:0] et[8], input logic [11:0] es[8]);
        check_val({tag, "_npkt"}, 128'(obs_len.size()), 128'(n));
        for (int i = 0; i < n && i < obs_len.size(); i++) begin
            check_val({tag, "_len"}, 128'(obs_len[i]), 128'(el[i]));
            check_val({tag, "_ts"}, 128'(obs_ts[i]), 128'(et[i]));
            check_val({tag, "_seq"}, 128'(obs_seq[i]), 128'(es[i]));
        end
    endtask

    function automatic logic [127:0] mk_hdr(input logic eob, input logic [63:0] t);
        logic [127:0] u;
        u = {$urandom, $urandom, $urandom, $urandom};
        u[124]  = eob;
        u[63:0] = t;
        return u;
    endfunction

    initial begin
        logic [127:0] u;
        int np;
        int nb;
        model_reset(1'b1);
        clear_obs();
        repeat (2) @(negedge clk);
        do_reset();
        check_pktcnt();

        // 10-beat burst, PKT_LEN=4, TIME_INC=2, without and with output stalls.
        for (int pass = 0; pass < 2; pass++) begin
            stall_en = (pass == 1);
            do_reset();
            write_reg(8'd128, 32'd4);
            write_reg(8'd129, 32'd2);
            send_pkt(10, mk_hdr(1'b1, 64'd1000));
            idle(2);
            check_pkts("len4", 3, '{4, 4, 2, 0, 0, 0, 0, 0},
                       '{64'd1000, 64'd1008, 64'd1016, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0},
                       '{12'd0, 12'd1, 12'd2, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
            check_pktcnt();
        end
        stall_en = 1'b0;

        // Three 3-beat input packets, only the last carrying EOB.
        do_reset();
        write_reg(8'd128, 32'd5);
        send_pkt(3, mk_hdr(1'b0, 64'd100));
        send_pkt(3, mk_hdr(1'b0, 64'd9999));
        send_pkt(3, mk_hdr(1'b1, 64'd7777));
        check_pkts("merge", 2, '{5, 4, 0, 0, 0, 0, 0, 0},
                   '{64'd100, 64'd105, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0},
                   '{12'd0, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});

        // PKT_LEN rewritten mid-packet takes effect only at the next packet.
        do_reset();
        write_reg(8'd128, 32'd4);
        u = mk_hdr(1'b1, 64'd300);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) write_reg(8'd128, 32'd2);
            send_beat($urandom, u, (i == 7));
        end
        check_pkts("lenchg", 3, '{4, 2, 2, 0, 0, 0, 0, 0},
                   '{64'd300, 64'd304, 64'd306, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0},
                   '{12'd0, 12'd1, 12'd2, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});

        // Reset mid-packet abandons it; a new burst restarts time and seqnum.
        do_reset();
        send_beat($urandom, mk_hdr(1'b0, 64'd777), 1'b0);
        send_beat($urandom, mk_hdr(1'b0, 64'd777), 1'b0);
        do_reset();
        check_pktcnt();
        send_pkt(3, mk_hdr(1'b1, 64'd50));
        check_pkts("rstmid", 1, '{3, 0, 0, 0, 0, 0, 0, 0},
                   '{64'd50, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0},
                   '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
        check_pktcnt();

        // Clear mid-packet keeps the programmed settings.
        do_reset();
        write_reg(8'd128, 32'd3);
        write_reg(8'd129, 32'd5);
        send_pkt(2, mk_hdr(1'b0, 64'd10));
        do_clear();
        check_pktcnt();
        send_pkt(4, mk_hdr(1'b1, 64'd60));
        check_pkts("clrmid", 2, '{3, 1, 0, 0, 0, 0, 0, 0},
                   '{64'd60, 64'd75, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0},
                   '{12'd0, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});

        // Seqnum wrap: 4095 single-beat packets, then two more.
        do_reset();
        write_reg(8'd128, 32'd1);
        u = mk_hdr(1'b1, 64'd0);
        for (int i = 0; i < 4097; i++) begin
            send_beat($urandom, u, (i == 4096));
        end
        check_val("wrap_seq4095", 128'(obs_seq[obs_seq.size() - 2]), 128'd4095);
        check_val("wrap_seq0", 128'(obs_seq[obs_seq.size() - 1]), 128'd0);
        check_pktcnt();

        // Randomized bursts with settings churn, gaps and output stalls.
        do_reset();
        stall_en = 1'b1;
        for (int b = 0; b < 30; b++) begin
            if ($urandom_range(0, 2) == 0) write_reg(8'd128, $urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) write_reg(8'd129, $urandom);
            if ($urandom_range(0, 4) == 0) write_reg(8'd130, $urandom);
            next_dst = 16'($urandom);
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                u  = mk_hdr(p == np - 1, {$urandom, $urandom});
                nb = $urandom_range(1, 6);
                for (int i = 0; i < nb; i++) begin
                    if ($urandom_range(0, 5) == 0) idle(1);
                    if ($urandom_range(0, 9) == 0) write_reg(8'd128, $urandom_range(0, 6));
                    send_beat($urandom, u, (i == nb - 1));
                end
            end
            if ($urandom_range(0, 9) == 0) do_clear();
        end
        idle(2);
        check_pktcnt();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_resize_timestamp.md
AXI_RESIZE_TIMESTAMP -- requirements
Module: axi_resize_timestamp

Interface
REQ-001 Parameter WIDTH, default 32: sample/beat data width in bits, any multiple of 8 from 8 to 256.
REQ-002 Parameter SR_BASE, default 8'd128: base settings-bus address; SR_BASE+0 is PKT_LEN, SR_BASE+1 is TIME_INC.
REQ-003 Parameter DEF_PKT_LEN, default 16'd256: PKT_LEN value after reset, in output beats.
REQ-004 Parameter DEF_TIME_INC, default 32'd1: TIME_INC value after reset, in VITA ticks per output beat.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 clear  in  1  synchronous flush, active-high; same effect as reset except that PKT_LEN and TIME_INC are kept.
REQ-008 set_stb, set_addr, set_data  in  1/8/32  settings bus.
REQ-009 next_dst  in  16  destination SID inserted into output headers.
REQ-010 s_axis_tdata, s_axis_tuser, s_axis_tlast, s_axis_tvalid  in  WIDTH/128/1/1  input stream; tuser is the CVITA header, held stable for the whole packet.
REQ-011 s_axis_tready  out  1  input ready.
REQ-012 m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid  out  WIDTH/128/1/1  resized output stream.
REQ-013 m_axis_tready  in  1  output ready.
REQ-014 rb_pkt_cnt  out  32  output packet count; present only when the Configuration macro is defined.

Function
REQ-015 Data path SHALL be combinational, with zero latency: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
REQ-016 Settings writes SHALL take effect at the start of the next output packet, never within a packet in progress.
REQ-017 A PKT_LEN value of 0 SHALL be treated as 1; TIME_INC SHALL use the low 32 bits of set_data.
REQ-018 State machine states SHALL be IDLE (awaiting first beat of a burst) and RUN (inside a burst).
- Transition IDLE->RUN on the first accepted beat.
- Transition RUN->IDLE on an accepted beat whose tlast is set with s_axis_tuser[124] (EOB) set.
REQ-019 On the IDLE->RUN beat the block SHALL latch has_time (tuser[125]), type (tuser[127:126]), src SID (tuser[79:64]) and time_accum = tuser[63:0].
REQ-020 Input header timestamps of later packets in the same burst SHALL be ignored.
REQ-021 Beat counter rules:
- Increments on each accepted beat.
- m_axis_tlast=1 when count = PKT_LEN-1, or on an input EOB tlast beat.
- Counter returns to 0 after any output tlast.
- Input tlast without EOB SHALL NOT end an output packet.
REQ-022 time_accum SHALL add TIME_INC, modulo 2^64, on every accepted beat; the timestamp of each output packet is time_accum at its first beat.
REQ-023 m_axis_tuser fields:
- [127:126] latched type.
- [125] latched has_time.
- [124] EOB, set only on the final beat of a burst.
- [123:112] seqnum.
- [111:96] zero (length is computed downstream).
- [95:80] latched src.
- [79:64] next_dst.
- [63:0] packet timestamp.
All fields except [124] SHALL be stable for the whole output packet.
REQ-024 seqnum SHALL start at 0, increment per output packet and wrap from 4095 to 0.
REQ-025 If tvalid is low or m_axis_tready is low, all counters and state SHALL hold.

Reset
REQ-026 On reset: state=IDLE, beat count=0, seqnum=0, time_accum=0, PKT_LEN=DEF_PKT_LEN, TIME_INC=DEF_TIME_INC, rb_pkt_cnt=0.
REQ-027 Outputs during reset follow REQ-015; m_axis_tuser=0 and m_axis_tlast=0 while the block is in reset.
REQ-028 Reset or clear asserted mid-packet SHALL abandon the packet; the next accepted beat is treated as a burst start.

Configuration
REQ-029 Macro AXI_RESIZE_TIMESTAMP_PKTCNT_EN defined:
- rb_pkt_cnt counts output tlast beats and wraps at 2^32.
- rb_pkt_cnt is cleared by reset or clear.
REQ-030 Macro AXI_RESIZE_TIMESTAMP_PKTCNT_EN undefined: the port and the counter are absent.

Verification
REQ-031 PKT_LEN=4, TIME_INC=2, one input packet of 10 beats with time 1000 and EOB -> outputs of 4/4/2 beats, times 1000/1008/1016, EOB on beat 10 only, seqnum 0/1/2.
REQ-032 Three input packets of 3 beats each (EOB on the last), PKT_LEN=5 -> outputs of 5 and 4 beats; second-packet input time ignored.
REQ-033 seqnum at 4095, then two output packets -> seqnum 4095 then 0.
REQ-034 Random m_axis_tready stalls during REQ-031 -> identical beats and headers; no beat lost or duplicated.
REQ-035 PKT_LEN written mid-packet from 4 to 2 -> current packet ends at 4 beats; next packet is 2 beats.
REQ-036 reset low at beat 2 of a packet, then a new burst with time 50 -> first output packet time 50, seqnum 0; rb_pkt_cnt=0 when the macro is enabled.
